// File: rtl/efuse_model_pkg.sv
// rtl/efuse_model_pkg.sv - shared types, error bit indices and sizes for the eFuse macro model
package efuse_model_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACT = 2'd1,
        PG_ACT = 2'd2,
        REC    = 2'd3
    } state_t;

    localparam int FUSE_BITS  = 256;
    localparam int FUSE_BYTES = 32;
    localparam int CNT_W      = 10;
    localparam int ERR_W      = 5;

    localparam int ERR_PGM_SHORT = 0;
    localparam int ERR_RD_EARLY  = 1;
    localparam int ERR_REC       = 2;
    localparam int ERR_ADDR      = 3;
    localparam int ERR_ABORT     = 4;

    // Pulse counters hold at all-ones instead of wrapping on very long pulses.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/efuse_pulse_timer.sv
// rtl/efuse_pulse_timer.sv - AEN edge detection and saturating high/low pulse-width counters
module efuse_pulse_timer
    import efuse_model_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             aen,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] lcnt
);

    logic aen_q;

    assign rise = aen & ~aen_q;
    assign fall = ~aen & aen_q;

    // aen_q resets high so an AEN held across reset is not seen as a new pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            aen_q <= 1'b1;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            aen_q <= aen;
            if (rise) begin
                hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (aen) begin
                hcnt <= sat_inc(hcnt);
            end
            if (fall) begin
                lcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!aen) begin
                lcnt <= sat_inc(lcnt);
            end
        end
    end

endmodule

// File: rtl/efuse_macro_model.sv
// rtl/efuse_macro_model.sv - 256-bit OTP eFuse macro responder with timing checks; EFUSE_MODEL_WPROT_EN adds the bit-255 write lock
module efuse_macro_model
    import efuse_model_pkg::*;
#(
    parameter int unsigned           RD_ACC_CYC  = 4,
    parameter int unsigned           PGM_MIN_CYC = 20,
    parameter int unsigned           REC_MIN_CYC = 9,
    parameter logic [FUSE_BITS-1:0]  FUSE_INIT   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             efuse_pgmen,
    input  logic             efuse_rden,
    input  logic             efuse_aen,
    input  logic [7:0]       efuse_addr,
    output logic [7:0]       efuse_d,
    output logic [ERR_W-1:0] err_pulse,
    output logic [ERR_W-1:0] err_status,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] RD_ACC  = RD_ACC_CYC[CNT_W-1:0];
    localparam logic [CNT_W-1:0] PGM_MIN = PGM_MIN_CYC[CNT_W-1:0];
    localparam logic [CNT_W-1:0] REC_MIN = REC_MIN_CYC[CNT_W-1:0];

    state_t               state_q, state_n;
    logic [FUSE_BITS-1:0] fuse_q;
    logic [7:0]           addr_q;
    logic                 rd_bad_q;
    logic                 blk_q;
    logic [7:0]           d_q;

    logic             rise, fall;
    logic [CNT_W-1:0] hcnt, lcnt;

    logic             rd_only, pg_only;
    logic             rd_bad, locked, lock_hit;
    logic             start, prog_set, load_d;
    logic [ERR_W-1:0] flags;

    efuse_pulse_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .aen  (efuse_aen),
        .rise (rise),
        .fall (fall),
        .hcnt (hcnt),
        .lcnt (lcnt)
    );

    assign rd_only = efuse_rden & ~efuse_pgmen;
    assign pg_only = efuse_pgmen & ~efuse_rden;
    assign rd_bad  = (efuse_addr >= 8'(FUSE_BYTES));

`ifdef EFUSE_MODEL_WPROT_EN
    assign locked = fuse_q[FUSE_BITS-1];
`else
    assign locked = 1'b0;
`endif
    // The lock bit itself is still a legal (no-op) target once set.
    assign lock_hit = locked && (efuse_addr != 8'hFF);

    always_comb begin
        state_n  = state_q;
        flags    = '0;
        start    = 1'b0;
        prog_set = 1'b0;
        load_d   = 1'b0;
        case (state_q)
            IDLE, REC: begin
                if (rise) begin
                    start = 1'b1;
                    if ((state_q == REC) && (lcnt < REC_MIN)) begin
                        flags[ERR_REC] = 1'b1;
                    end
                    if (rd_only) begin
                        state_n = RD_ACT;
                        flags[ERR_ADDR] = rd_bad;
                    end else if (pg_only) begin
                        state_n = PG_ACT;
                        flags[ERR_ADDR] = lock_hit;
                    end else begin
                        state_n = IDLE;
                        flags[ERR_ABORT] = 1'b1;
                    end
                end else if ((state_q == REC) && (lcnt >= REC_MIN)) begin
                    state_n = IDLE;
                end
            end
            RD_ACT: begin
                if (fall) begin
                    state_n = REC;
                    if (hcnt < RD_ACC) begin
                        flags[ERR_RD_EARLY] = 1'b1;
                    end else if ((hcnt == RD_ACC) && !rd_bad_q) begin
                        load_d = 1'b1;
                    end
                end else if (!rd_only) begin
                    state_n = IDLE;
                    flags[ERR_ABORT] = 1'b1;
                end else if ((hcnt == RD_ACC) && !rd_bad_q) begin
                    load_d = 1'b1;
                end
            end
            PG_ACT: begin
                if (fall) begin
                    state_n = REC;
                    if (hcnt >= PGM_MIN) begin
                        prog_set = !blk_q;
                    end else begin
                        flags[ERR_PGM_SHORT] = 1'b1;
                    end
                end else if (!pg_only) begin
                    state_n = IDLE;
                    flags[ERR_ABORT] = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fuse_q     <= FUSE_INIT;
            addr_q     <= '0;
            rd_bad_q   <= 1'b0;
            blk_q      <= 1'b0;
            d_q        <= '0;
            err_pulse  <= '0;
            err_status <= '0;
        end else begin
            state_q   <= state_n;
            err_pulse <= flags;
            // Clear wins over flags raised in the same cycle; err_pulse still shows them.
            err_status <= err_clr ? '0 : (err_status | flags);
            if (start) begin
                addr_q   <= efuse_addr;
                rd_bad_q <= rd_bad;
                blk_q    <= lock_hit;
            end
            if (start || !efuse_rden) begin
                d_q <= '0;
            end else if (load_d) begin
                d_q <= fuse_q[{addr_q[4:0], 3'b000} +: 8];
            end
            if (prog_set) begin
                fuse_q[addr_q] <= 1'b1;
            end
        end
    end

    assign efuse_d = (efuse_rden && !efuse_pgmen) ? d_q : 8'h00;

endmodule

// File: tb/tb_efuse_macro_model.sv
// tb/tb_efuse_macro_model.sv - randomized self-checking bench for efuse_macro_model against a transaction-level model
module tb_efuse_macro_model;

    localparam int K_RD   = 0;
    localparam int K_PG   = 1;
    localparam int K_NONE = 2;
    localparam int K_CONF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pgmen, rden, aen, err_clr;
    logic [7:0] addr;
    logic [7:0] efuse_d;
    logic [4:0] err_pulse, err_status;

    always #5 clk = ~clk;

    efuse_macro_model dut (
        .clk         (clk),
        .rst         (rst),
        .efuse_pgmen (pgmen),
        .efuse_rden  (rden),
        .efuse_aen   (aen),
        .efuse_addr  (addr),
        .efuse_d     (efuse_d),
        .err_pulse   (err_pulse),
        .err_status  (err_status),
        .err_clr     (err_clr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: fuse contents, sticky errors, and whether the last pulse was a real access.
    logic [255:0] m_fuse;
    logic [4:0]   m_status;
    bit           m_in_rec;
    int           m_low;

    logic [4:0]   seen;
    int           pcnt;
    logic [7:0]   dval;

    function automatic logic [7:0] m_byte(input int a);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = m_fuse[8*a + b];
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        m_low += n;
    endtask

    task automatic tx(input int kind, input logic [7:0] a, input int hi, input int lo,
                      input bit clr_fall, input string tag);
        logic [4:0] ef;
        logic [7:0] ed;
        bit         lk;
        ef = '0;
        ed = '0;
        lk = 1'b0;
        if (m_in_rec && m_low < 9) ef[2] = 1'b1;
`ifdef EFUSE_MODEL_WPROT_EN
        lk = m_fuse[255] && (a != 8'hFF);
`endif
        case (kind)
            K_RD: begin
                if (a >= 8'd32) ef[3] = 1'b1;
                if (hi < 4) ef[1] = 1'b1;
                if (a < 8'd32 && hi >= 4) ed = m_byte(int'(a));
            end
            K_PG: begin
                if (lk) ef[3] = 1'b1;
                if (hi < 20) ef[0] = 1'b1;
                else if (!lk) m_fuse[a] = 1'b1;
            end
            default: ef[4] = 1'b1;
        endcase

        pgmen = (kind == K_PG) || (kind == K_CONF);
        rden  = (kind == K_RD) || (kind == K_CONF);
        addr  = a;
        aen   = 1'b1;
        seen  = '0;
        pcnt  = 0;
        repeat (hi) begin
            @(negedge clk);
            seen |= err_pulse;
            if (err_pulse != 0) pcnt++;
        end
        aen = 1'b0;
        if (clr_fall) err_clr = 1'b1;
        for (int i = 0; i < lo; i++) begin
            @(negedge clk);
            err_clr = 1'b0;
            seen |= err_pulse;
            if (err_pulse != 0) pcnt++;
        end
        dval = efuse_d;

        m_status = clr_fall ? 5'b0 : (m_status | ef);
        m_in_rec = (kind == K_RD) || (kind == K_PG);
        m_low    = lo;
        chk({tag, ".flags"},  32'(seen),       32'(ef));
        chk({tag, ".d"},      32'(dval),       32'(ed));
        chk({tag, ".status"}, 32'(err_status), 32'(m_status));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hi, lo;
        logic [7:0] a;

        rst = 1'b1; pgmen = 1'b0; rden = 1'b0; aen = 1'b0; err_clr = 1'b0; addr = '0;
        m_fuse = '0; m_status = '0; m_in_rec = 1'b0; m_low = 0;
        repeat (3) @(negedge clk);
        chk("reset.d",      32'(efuse_d),    32'h0);
        chk("reset.pulse",  32'(err_pulse),  32'h0);
        chk("reset.status", 32'(err_status), 32'h0);
        rst = 1'b0;
        idle(12);

        tx(K_RD, 8'd3, 6, 9, 1'b0, "rd3_blank");
        tx(K_PG, 8'd26, 20, 9, 1'b0, "pg26");
        tx(K_RD, 8'd3, 6, 9, 1'b0, "rd3_after_pg26");
        chk("rd3_value", 32'(dval), 32'h04);
        tx(K_PG, 8'd5, 20, 9, 1'b0, "pg5");
        tx(K_PG, 8'd7, 19, 9, 1'b0, "pg7_short");
        chk("pg7_short.pulse_cycles", 32'(pcnt), 32'd1);
        chk("pg7_short.status_bits", 32'(err_status), 32'h01);
        tx(K_RD, 8'd0, 6, 9, 1'b0, "rd0_bit7_clear");
        tx(K_RD, 8'd0, 3, 5, 1'b0, "rd0_early");
        tx(K_RD, 8'd0, 6, 9, 1'b0, "rd0_rec");
        tx(K_CONF, 8'd26, 6, 9, 1'b0, "conflict");
        tx(K_RD, 8'h20, 6, 9, 1'b0, "rd_bad_addr");
        tx(K_NONE, 8'd4, 5, 9, 1'b0, "no_enable");

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 9));
            lo = int'($urandom_range(3, 12));
            if (k <= 4) begin
                a  = 8'($urandom_range(0, 39));
                hi = int'($urandom_range(2, 8));
                tx(K_RD, a, hi, lo, 1'b0, "rnd_rd");
            end else if (k <= 8) begin
                a  = 8'($urandom_range(0, 254));
                hi = int'($urandom_range(17, 23));
                tx(K_PG, a, hi, lo, 1'b0, "rnd_pg");
            end else begin
                hi = int'($urandom_range(1, 6));
                tx(($urandom_range(0, 1) != 0) ? K_CONF : K_NONE, 8'd0, hi, lo, 1'b0, "rnd_abort");
            end
        end

        tx(K_PG, 8'd255, 20, 9, 1'b0, "pg255");
        tx(K_PG, 8'd0, 20, 9, 1'b0, "pg0_after_255");
        tx(K_RD, 8'd0, 6, 9, 1'b0, "rd0_after_lock");
        tx(K_RD, 8'd31, 6, 9, 1'b0, "rd31");

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_status = '0;
        m_low += 1;
        chk("err_clr.status", 32'(err_status), 32'h0);
        tx(K_PG, 8'd7, 10, 9, 1'b1, "short_with_clr");

        // Reset while a program pulse is mid-flight; AEN stays high afterwards.
        pgmen = 1'b1; rden = 1'b0; addr = 8'd9; aen = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_fuse = '0; m_status = '0; m_in_rec = 1'b0;
        seen = '0;
        repeat (15) begin
            @(negedge clk);
            seen |= err_pulse;
        end
        aen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= err_pulse;
        end
        m_low = 12;
        chk("rst_mid.flags",  32'(seen),       32'h0);
        chk("rst_mid.status", 32'(err_status), 32'h0);
        tx(K_RD, 8'd1, 6, 9, 1'b0, "rd1_after_rst");
        tx(K_RD, 8'd3, 6, 9, 1'b0, "rd3_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
